icache: RTL
===========

ICACHE -- requirements
Module: icache

Interface
REQ-001 Parameter LINES, default 16, number of direct-mapped lines (power of two, >=2).
REQ-002 Parameter WORDS, default 4, 32-bit words per line (power of two, >=2).
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 cpu_addr  input  25  fetch byte address; bits [1:0] ignored.
REQ-006 cpu_enable  input  1  fetch request; held high with stable cpu_addr until cpu_valid.
REQ-007 cpu_valid  output  1  one-cycle pulse; cpu_result holds the fetched word.
REQ-008 cpu_result  output  32  instruction word.
REQ-009 inval  input  1  invalidate all lines.
REQ-010 mem_addr  output  25  backend word address (bits [1:0] = 0).
REQ-011 mem_enable  output  1  backend read request; held with stable mem_addr until mem_valid.
REQ-012 mem_valid  input  1  backend data ready, one-cycle pulse.
REQ-013 mem_result  input  32  backend read data.

Function
REQ-014 Address split: offset = addr[log2(WORDS)+1:2], index = next log2(LINES) bits, tag = remaining upper bits (17 bits at defaults).
REQ-015 Storage: per line valid bit, tag, WORDS data words; all outputs registered.
REQ-016 States IDLE, LOOKUP, REFILL; reset state IDLE.
REQ-017 IDLE: cpu_enable=1 -> latch cpu_addr, go LOOKUP; otherwise stay.
REQ-018 LOOKUP hit (valid & tag match): cpu_valid=1 and cpu_result=word[offset] in next cycle, go IDLE.
REQ-019 Hit latency: cpu_enable sampled in cycle T -> cpu_valid in cycle T+2; no backend activity.
REQ-020 LOOKUP miss: clear line valid bit, reset word counter to 0, go REFILL.
REQ-021 REFILL: request words line_base+0..WORDS-1 in ascending order, line_base = latched addr with offset and byte bits zeroed.
REQ-022 Each word: mem_enable=1 with mem_addr stable until mem_valid; on mem_valid store mem_result into word[counter], counter+1, mem_enable=0 for exactly one cycle.
REQ-023 After last word stored: write tag, set valid, return to LOOKUP (guaranteed hit); miss latency = refill time + 2 cycles.
REQ-024 mem_valid outside REFILL, or while mem_enable=0, ignored.
REQ-025 Requests not abortable: cpu_enable dropping mid-refill still completes refill; cpu_valid still pulses once.
REQ-026 cpu_valid never asserted twice per request; IDLE is occupied at least one cycle between responses.
REQ-027 inval in IDLE: all valid bits cleared in that cycle; simultaneous cpu_enable accepted and looked up after clearing (misses).
REQ-028 inval in LOOKUP/REFILL: latched as pending; in-flight request completes with correct data; pending clear applied on IDLE entry, after which pending is cleared.
REQ-029 Index wrap: counter wraps 0..WORDS-1 only; mem_addr never crosses the line boundary.

Reset
REQ-030 While rst=1: state IDLE, all valid bits 0, inval pending 0, counter 0, cpu_valid 0, cpu_result 0, mem_enable 0, mem_addr 0.
REQ-031 Reset mid-refill: mem_enable 0 in the following cycle; partially filled line stays invalid; tag/data contents need not be cleared.

Verification
REQ-032 Cold miss, cpu_addr 0x0000010 -> mem_addr 0x10,0x14,0x18,0x1C in order; cpu_valid once with word from 0x10.
REQ-033 Then fetch 0x0000018 -> cpu_valid exactly 2 cycles after cpu_enable, data from 0x18, mem_enable never high.
REQ-034 Conflict: fetch 0x0000110 (same index 1, new tag) -> refill 0x110-0x11C; refetch 0x10 -> misses again.
REQ-035 inval pulse during REFILL word 1 -> fetch completes correctly; next fetch of same line misses and refills.
REQ-036 rst pulse during REFILL word 2 -> mem_enable 0 next cycle, cpu_valid 0; refetch same address performs full 4-word refill.
REQ-037 Backend with random 0-5 cycle mem_valid delay over 1000 random fetches in 0x000-0x3FF -> every cpu_result matches memory model.

Source files
------------

// File: rtl/icache_if.sv
// CPU fetch port and backend read port of the instruction cache.
// The slave view belongs to the cache; the master view belongs to the CPU and backend side.
interface icache_if;
  logic [24:0] cpu_addr;
  logic        cpu_enable;
  logic        cpu_valid;
  logic [31:0] cpu_result;
  logic        inval;
  logic [24:0] mem_addr;
  logic        mem_enable;
  logic        mem_valid;
  logic [31:0] mem_result;

  modport slave (
    input  cpu_addr, cpu_enable, inval, mem_valid, mem_result,
    output cpu_valid, cpu_result, mem_addr, mem_enable
  );

  modport master (
    output cpu_addr, cpu_enable, inval, mem_valid, mem_result,
    input  cpu_valid, cpu_result, mem_addr, mem_enable
  );
endinterface

// File: rtl/icache.sv
// Direct-mapped instruction cache with whole-line refill from a word-wide backend.
// Only a line that has been completely refilled is ever marked valid.
module icache #(
  parameter int unsigned LINES = 16,
  parameter int unsigned WORDS = 4
) (
  input  logic    clk,
  input  logic    rst,
  icache_if.slave bus
);
  localparam int unsigned OFF_W = $clog2(WORDS);
  localparam int unsigned IDX_W = $clog2(LINES);
  localparam int unsigned TAG_W = 25 - 2 - OFF_W - IDX_W;

  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_REFILL} state_t;

  state_t             r_state;
  logic [24:0]        r_addr;
  logic [LINES-1:0]   r_valid;
  logic [TAG_W-1:0]   r_tag  [LINES];
  logic [31:0]        r_data [LINES*WORDS];
  logic [OFF_W-1:0]   r_cnt;
  logic               r_inval_pend;
  logic               r_cpu_valid;
  logic [31:0]        r_cpu_result;
  logic               r_mem_enable;
  logic [24:0]        r_mem_addr;

  logic [IDX_W-1:0]   w_idx;
  logic [OFF_W-1:0]   w_off;
  logic [TAG_W-1:0]   w_tag;
  logic               w_hit;
  logic               w_last;
  logic               w_store;

  assign w_off   = r_addr[2 +: OFF_W];
  assign w_idx   = r_addr[2 + OFF_W +: IDX_W];
  assign w_tag   = r_addr[2 + OFF_W + IDX_W +: TAG_W];
  assign w_hit   = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_last  = (r_cnt == OFF_W'(WORDS - 1));
  assign w_store = (r_state == S_REFILL) && r_mem_enable && bus.mem_valid && !rst;

  // Tag and data arrays carry no reset; the valid bits alone guard them.
  always_ff @(posedge clk) begin
    if (w_store) begin
      r_data[{w_idx, r_cnt}] <= bus.mem_result;
      if (w_last) r_tag[w_idx] <= w_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_valid      <= '0;
      r_cnt        <= '0;
      r_inval_pend <= 1'b0;
      r_cpu_valid  <= 1'b0;
      r_cpu_result <= '0;
      r_mem_enable <= 1'b0;
      r_mem_addr   <= '0;
    end else begin
      r_cpu_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.inval) r_valid <= '0;
          if (bus.cpu_enable) begin
            r_addr  <= bus.cpu_addr & ~25'h3;
            r_state <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (w_hit) begin
            r_cpu_valid  <= 1'b1;
            r_cpu_result <= r_data[{w_idx, w_off}];
            r_state      <= S_IDLE;
            // Deferred invalidate lands as we return to IDLE.
            if (bus.inval || r_inval_pend) r_valid <= '0;
            r_inval_pend <= 1'b0;
          end else begin
            r_valid[w_idx] <= 1'b0;
            r_cnt          <= '0;
            r_state        <= S_REFILL;
            if (bus.inval) r_inval_pend <= 1'b1;
          end
        end
        S_REFILL: begin
          if (bus.inval) r_inval_pend <= 1'b1;
          if (r_mem_enable) begin
            if (bus.mem_valid) begin
              r_mem_enable <= 1'b0;
              r_cnt        <= r_cnt + OFF_W'(1);
              if (w_last) begin
                r_valid[w_idx] <= 1'b1;
                r_state        <= S_LOOKUP;
              end
            end
          end else begin
            // Request the next word of the line; r_addr[1:0] is always zero.
            r_mem_enable <= 1'b1;
            r_mem_addr   <= {r_addr[24:OFF_W+2], r_cnt, r_addr[1:0]};
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.cpu_valid  = r_cpu_valid;
  assign bus.cpu_result = r_cpu_result;
  assign bus.mem_enable = r_mem_enable;
  assign bus.mem_addr   = r_mem_addr;
endmodule
